// File: rtl/memfile_param.sv
// memfile_param: DEPTH x DATA_W register-file RAM with registered read, range check and bulk clear.
// Define MEM_PARITY_EN to add a per-row even-parity bit and a sticky perr flag.
module memfile_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clkp,
  input  logic              rstp,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic              err,
  output logic              busy,
  output logic              perr
);

`ifdef MEM_PARITY_EN
  localparam int ROW_W = DATA_W + 1;
`else
  localparam int ROW_W = DATA_W;
`endif
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ROW_W-1:0]  mem [0:DEPTH-1];
  logic [ADDR_W-1:0] cnt;
  logic              inrange;
  logic [ROW_W-1:0]  row;
  logic [ROW_W-1:0]  wrow;

  always_comb begin
    inrange = ({1'b0, addr} < DEPTH_X);
    row     = inrange ? mem[addr] : '0;
`ifdef MEM_PARITY_EN
    wrow    = {^din, din};
`else
    wrow    = din;
`endif
  end

`ifndef MEM_PARITY_EN
  assign perr = 1'b0;
`endif

  // Accesses are served first; the clear sequencer then owns the array while busy.
  always_ff @(posedge clkp or posedge rstp) begin
    if (rstp) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      dout   <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
`ifdef MEM_PARITY_EN
      perr   <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      if (cs && busy) begin
        err <= 1'b1;
      end else if (cs && we) begin
        if (inrange) mem[addr] <= wrow;
        else         err       <= 1'b1;
      end else if (cs) begin
        rvalid <= 1'b1;
        err    <= !inrange;
        dout   <= inrange ? row[DATA_W-1:0] : '0;
`ifdef MEM_PARITY_EN
        if (inrange && ^row) perr <= 1'b1;
`endif
      end

      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          mem[cnt] <= '0;
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
`ifdef MEM_PARITY_EN
            perr  <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/memfile_param.md
Name: memfile_param

Overview:
- Parametrised register-file memory: DEPTH rows of DATA_W flip-flop storage, single shared port, chip-select/write-enable access.
- Used as the SoC's small scratch/data RAM, directly on the CPU data bus.
- Over the fixed 3-row part it adds:
  - a registered read with a valid strobe;
  - out-of-range address detection;
  - a sequenced bulk-clear engine with a busy handshake.

Parameters:
DATA_W, 16, word width in bits (>=1)
ADDR_W, 3, address width in bits
DEPTH, 8, number of implemented rows (1 .. 2**ADDR_W); addresses >= DEPTH are out of range

Ports:
clkp  input  1  clock, all state updates on rising edge
rstp  input  1  reset, asynchronous, active-high
cs  input  1  chip select
we  input  1  1 = write, 0 = read (qualified by cs)
addr  input  ADDR_W  row address
din  input  DATA_W  write data
clr  input  1  single-cycle request to zero all rows
dout  output  DATA_W  registered read data
rvalid  output  1  one-cycle strobe, dout updated by a read
err  output  1  one-cycle strobe, access rejected or out of range
busy  output  1  clear engine active; accesses not accepted
perr  output  1  sticky parity error (see Optional Feature)

Behaviour:
- Reset (rstp=1, asynchronous):
  - all rows = 0; dout = 0; rvalid = 0; err = 0; busy = 0; perr = 0.
  - FSM = IDLE; clear counter = 0.
  - Reset mid-clear aborts the clear immediately; the state is then indistinguishable from a fresh reset.
- Access accepted on a rising edge when cs=1 and busy=0.
- Write (cs=1, we=1, busy=0):
  - addr < DEPTH: row[addr] <= din at this edge. The new value is readable by a read in the next cycle.
  - addr >= DEPTH: no row changes; err=1 in the following cycle only.
  - rvalid stays 0; dout unchanged.
- Read (cs=1, we=0, busy=0):
  - addr < DEPTH: dout <= row[addr] at this edge; rvalid=1 for exactly the following cycle. Latency is 1 cycle.
  - addr >= DEPTH: dout <= 0; rvalid=1 and err=1 for the following cycle.
- No accepted read: dout holds its last value indefinitely; rvalid=0.
- cs=0: no effect; err=0.
- Clear FSM, two states IDLE and CLEAR:
  - IDLE -> CLEAR on a clkp edge with clr=1. Counter <= 0; busy=1 from the next cycle.
  - CLEAR: each cycle row[counter] <= 0 and counter increments.
  - When counter = DEPTH-1 that row is cleared, FSM -> IDLE, busy=0 in the next cycle.
  - Total busy duration is exactly DEPTH cycles.
- Simultaneous events:
  - clr with an accepted access in the same cycle: the access is performed at that edge (write lands, read returns pre-clear data), then the clear runs. A row written in that cycle ends at 0.
  - clr while busy=1 is ignored (no restart, no err).
  - cs=1 while busy=1: access dropped, no row change, dout held, rvalid=0, err=1 for the following cycle.
- dout is unaffected by the clear; it keeps the last read value.
- Counter width is ADDR_W; no wrap beyond DEPTH-1.
- DEPTH = 2**ADDR_W is legal: no address is out of range and err then fires only for busy rejections.

Optional Feature:
- Macro MEM_PARITY_EN.
- Defined:
  - each row stores one extra even-parity bit, computed from din on write; clear writes data 0 with parity 0.
  - On an in-range read, parity is recomputed. On mismatch perr is set in the same cycle rvalid is asserted.
  - perr is sticky until rstp or completion of a clear. dout still returns the stored data.
- Not defined:
  - no parity storage; perr is constant 0.
  - Port list unchanged.

Test Plan:
1. Reset, then write 0xA5A5 to addr 2 and 0x1234 to addr 7, read addr 2 then addr 7. Required: dout=0xA5A5, then 0x1234, each with rvalid=1 exactly one cycle after the read edge; err=0 throughout.
2. DEPTH=6 build: write 0xFFFF to addr 6, then read addr 7. Required: err pulse after the write; no row changes. The read gives dout=0, rvalid=1, err=1.
3. Fill all 8 rows with 0x1111*(n+1), pulse clr. Required: busy=1 for exactly 8 cycles. A read of addr 0 issued during busy gives err=1, rvalid=0, dout held. Reads of all rows afterwards return 0.
4. Same-cycle write 0xBEEF to addr 0 plus clr. Required: clear runs 8 cycles; a read of addr 0 afterwards returns 0. A second clr during busy does not extend busy.
5. Assert rstp mid-clear (cycle 3 of 8) after the rows were filled. Required: busy=0, dout=0, rvalid=err=0 immediately. All rows read 0; a new write/read of 0x00FF works.
6. MEM_PARITY_EN build: write 0x0001 to addr 4, force one stored data bit of row 4 by backdoor, read addr 4. Required: perr=1 with rvalid; perr stays 1 until clr completes. Without the macro, perr=0.
